// File: rtl/imm_pkg.sv
// Shared constants and types for the pixel transfer link receiver.
package imm_pkg;

  localparam int unsigned IMG_ROWS = 240;
  localparam int unsigned IMG_COLS = 320;
  localparam int unsigned PIX_W    = 12;
  localparam int unsigned ROW_W    = 8;
  localparam int unsigned COL_W    = 9;

  typedef enum logic [0:0] {
    RX_IDLE,
    RX_RECV
  } rx_state_e;

endpackage

// File: rtl/raster_position_counter.sv
// Expected (row, col) position of the next pixel, advancing in raster order.
module raster_position_counter #(
  parameter int unsigned Rows = imm_pkg::IMG_ROWS,
  parameter int unsigned Cols = imm_pkg::IMG_COLS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       advance_i,
  input  logic                       restart_to_01_i,
  input  logic                       clear_i,
  output logic [imm_pkg::ROW_W-1:0]  exp_row_o,
  output logic [imm_pkg::COL_W-1:0]  exp_col_o,
  output logic                       is_last_o
);
  localparam logic [imm_pkg::ROW_W-1:0] LastRow = imm_pkg::ROW_W'(Rows - 1);
  localparam logic [imm_pkg::COL_W-1:0] LastCol = imm_pkg::COL_W'(Cols - 1);

  logic [imm_pkg::ROW_W-1:0] row_q, row_d;
  logic [imm_pkg::COL_W-1:0] col_q, col_d;

  // Next position: clear beats restart beats advance; wraps to (0,0) after the last pixel.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (restart_to_01_i) begin
      row_d = '0;
      col_d = imm_pkg::COL_W'(1);
    end else if (advance_i) begin
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = (row_q == LastRow) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign exp_row_o = row_q;
  assign exp_col_o = col_q;
  assign is_last_o = (row_q == LastRow) && (col_q == LastCol);

endmodule

// File: rtl/pixel_stream_receiver.sv
// Receives the raster-ordered pixel stream, writes in-order pixels to the frame
// buffer and flags sequence errors.
module pixel_stream_receiver #(
  parameter int unsigned IMG_ROWS = imm_pkg::IMG_ROWS,
  parameter int unsigned IMG_COLS = imm_pkg::IMG_COLS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_valid,
  input  logic [imm_pkg::PIX_W-1:0]  pixel_in,
  input  logic [imm_pkg::ROW_W-1:0]  pix_row,
  input  logic [imm_pkg::COL_W-1:0]  pix_col,
  output logic                       wr_en,
  output logic [imm_pkg::ROW_W-1:0]  wr_row,
  output logic [imm_pkg::COL_W-1:0]  wr_col,
  output logic [imm_pkg::PIX_W-1:0]  wr_data,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       seq_error,
  output logic [7:0]                 err_count,
  output logic [7:0]                 frame_count
);
  imm_pkg::rx_state_e state_q, state_d;

  logic [imm_pkg::ROW_W-1:0] exp_row;
  logic [imm_pkg::COL_W-1:0] exp_col;
  logic                      is_last;
  logic                      advance, restart_to_01, clear;

  logic                      wr_en_q, wr_en_d;
  logic [imm_pkg::ROW_W-1:0] wr_row_q, wr_row_d;
  logic [imm_pkg::COL_W-1:0] wr_col_q, wr_col_d;
  logic [imm_pkg::PIX_W-1:0] wr_data_q, wr_data_d;
  logic                      frame_done_q, frame_done_d;
  logic                      seq_error_q, seq_error_d;
  logic [7:0]                err_count_q, err_count_d;
  logic [7:0]                frame_count_q, frame_count_d;

  logic tag_match, tag_origin;

  raster_position_counter #(
    .Rows (IMG_ROWS),
    .Cols (IMG_COLS)
  ) u_pos (
    .clk             (clk),
    .rst_n           (rst_n),
    .advance_i       (advance),
    .restart_to_01_i (restart_to_01),
    .clear_i         (clear),
    .exp_row_o       (exp_row),
    .exp_col_o       (exp_col),
    .is_last_o       (is_last)
  );

  // Out-of-range tags can never equal the in-range expected position.
  assign tag_match  = (pix_row == exp_row) && (pix_col == exp_col);
  assign tag_origin = (pix_row == '0) && (pix_col == '0);

  // Receiver FSM, counter control and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    advance       = 1'b0;
    restart_to_01 = 1'b0;
    clear         = 1'b0;
    wr_en_d       = 1'b0;
    wr_row_d      = wr_row_q;
    wr_col_d      = wr_col_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    seq_error_d   = 1'b0;
    err_count_d   = err_count_q;
    frame_count_d = frame_count_q;
    if (pix_valid) begin
      unique case (state_q)
        imm_pkg::RX_IDLE: begin
          if (tag_origin) begin
            wr_en_d       = 1'b1;
            restart_to_01 = 1'b1;
            state_d       = imm_pkg::RX_RECV;
          end
        end
        imm_pkg::RX_RECV: begin
          if (tag_match) begin
            wr_en_d = 1'b1;
            advance = 1'b1;
            if (is_last) begin
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 8'd1;
              state_d       = imm_pkg::RX_IDLE;
            end
          end else begin
            seq_error_d = 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
            if (tag_origin) begin
              wr_en_d       = 1'b1;
              restart_to_01 = 1'b1;
            end else begin
              clear   = 1'b1;
              state_d = imm_pkg::RX_IDLE;
            end
          end
        end
        default: state_d = imm_pkg::RX_IDLE;
      endcase
      if (wr_en_d) begin
        wr_row_d  = pix_row;
        wr_col_d  = pix_col;
        wr_data_d = pixel_in;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= imm_pkg::RX_IDLE;
      wr_en_q       <= 1'b0;
      wr_row_q      <= '0;
      wr_col_q      <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      seq_error_q   <= 1'b0;
      err_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      seq_error_q   <= seq_error_d;
      err_count_q   <= err_count_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_data     = wr_data_q;
  assign busy        = (state_q == imm_pkg::RX_RECV);
  assign frame_done  = frame_done_q;
  assign seq_error   = seq_error_q;
  assign err_count   = err_count_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_stream_receiver.sv
// Scoreboard bench for pixel_stream_receiver on a 4x5 frame.
module tb_pixel_stream_receiver;
  localparam int Rows = 4;
  localparam int Cols = 5;
  localparam int NPix = Rows * Cols;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [11:0] pixel_in = '0;
  logic [7:0]  pix_row = '0;
  logic [8:0]  pix_col = '0;
  logic        wr_en, busy, frame_done, seq_error;
  logic [7:0]  wr_row, err_count, frame_count;
  logic [8:0]  wr_col;
  logic [11:0] wr_data;

  pixel_stream_receiver #(
    .IMG_ROWS (Rows),
    .IMG_COLS (Cols)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pixel_in    (pixel_in),
    .pix_row     (pix_row),
    .pix_col     (pix_col),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .seq_error   (seq_error),
    .err_count   (err_count),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    bit          wr;
    logic [7:0]  row;
    logic [8:0]  col;
    logic [11:0] data;
    bit          fd;
    bit          se;
  } rec_t;

  rec_t        q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [28:0] last_wr = '0;

  // Reference model: frame progress as a linear pixel index.
  bit m_in_frame = 1'b0;
  int m_next = 0;
  int m_errs = 0;
  int m_frames = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(bit v, int r, int c, logic [11:0] d);
    int   idx;
    rec_t e;
    idx = (r < Rows && c < Cols) ? r * Cols + c : -1;
    e.stamp = cyc + 1;
    e.wr = 0; e.fd = 0; e.se = 0;
    e.row = 8'(r); e.col = 9'(c); e.data = d;
    if (v) begin
      if (!m_in_frame) begin
        if (idx == 0) begin
          e.wr = 1; m_in_frame = 1; m_next = 1;
        end
      end else if (idx == m_next) begin
        e.wr = 1;
        m_next++;
        if (m_next == NPix) begin
          e.fd = 1; m_in_frame = 0; m_frames = (m_frames + 1) % 256;
        end
      end else begin
        e.se = 1;
        if (m_errs < 255) m_errs++;
        if (idx == 0) begin
          e.wr = 1; m_next = 1;
        end else begin
          m_in_frame = 0;
        end
      end
    end
    if (e.wr || e.fd || e.se) q.push_back(e);
  endtask

  task automatic send(bit v, int r, int c, logic [11:0] d);
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_in_frame));
    check("err_count", 32'(err_count), 32'(m_errs));
    check("frame_count", 32'(frame_count), 32'(m_frames));
    pix_valid = v;
    pix_row   = 8'(r);
    pix_col   = 9'(c);
    pixel_in  = d;
    model_step(v, r, c, d);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) send(0, 0, 0, 12'h000);
  endtask

  task automatic frame(bit gaps);
    for (int i = 0; i < NPix; i++) begin
      send(1, i / Cols, i % Cols, 12'(12'h100 + i));
      if (gaps) send(0, 0, 0, 12'hFFF);
    end
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_wr_pos_data"}, 32'({wr_row, wr_col, wr_data}), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pulses"}, 32'({frame_done, seq_error}), 0);
    check({tag, "_counts"}, 32'({err_count, frame_count}), 0);
  endtask

  task automatic model_reset();
    q.delete();
    last_wr = '0;
    m_in_frame = 0; m_next = 0; m_errs = 0; m_frames = 0;
  endtask

  // Drain: every expected response must have appeared within a few cycles.
  task automatic drain(string tag);
    for (int i = 0; i < 8 && q.size() != 0; i++) idle(1);
    idle(1);
    check({tag, "_queue_empty"}, 32'(q.size()), 0);
  endtask

  // Monitor: compares DUT responses against the scoreboard queue.
  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() != 0 && q[0].stamp < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_output: got none expected wr=%0d fd=%0d se=%0d (cycle %0d)",
                 q[0].wr, q[0].fd, q[0].se, cyc);
        void'(q.pop_front());
      end
      if (wr_en || frame_done || seq_error) begin
        if (q.size() == 0 || q[0].stamp != cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got wr=%0d fd=%0d se=%0d expected none (cycle %0d)",
                   wr_en, frame_done, seq_error, cyc);
        end else begin
          rec_t e;
          e = q.pop_front();
          check("wr_en", 32'(wr_en), 32'(e.wr));
          check("frame_done", 32'(frame_done), 32'(e.fd));
          check("seq_error", 32'(seq_error), 32'(e.se));
          if (e.wr) begin
            check("wr_pos_data", 32'({wr_row, wr_col, wr_data}), 32'({e.row, e.col, e.data}));
            last_wr = {e.row, e.col, e.data};
          end
        end
      end else begin
        check("wr_hold", 32'({wr_row, wr_col, wr_data}), 32'(last_wr));
      end
    end
  end

  initial begin
    int cursor;
    int roll;
    // Power-on reset.
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 mon_en = 1'b1;

    // Full frame, back-to-back.
    frame(0);
    drain("frame");
    check("frame1_count", 32'(frame_count), 1);
    check("frame1_errs", 32'(err_count), 0);

    // Same frame with gaps on every other cycle.
    frame(1);
    drain("gap_frame");

    // Stream starting mid-frame before (0,0).
    for (int i = 7; i < NPix; i++) send(1, i / Cols, i % Cols, 12'(12'h200 + i));
    frame(0);
    drain("late_start");

    // Skip (0,2) after (0,1); then restart; then mid-frame (0,0).
    send(1, 0, 0, 12'hA00);
    send(1, 0, 1, 12'hA01);
    send(1, 0, 3, 12'hA03);
    drain("skip");
    check("skip_errs", 32'(err_count), 1);
    check("skip_busy", 32'(busy), 0);
    send(1, 0, 0, 12'hB00);
    send(1, 0, 1, 12'hB01);
    send(1, 0, 0, 12'hC00);
    for (int i = 1; i < NPix; i++) send(1, i / Cols, i % Cols, 12'(12'hC00 + i));
    drain("restart");

    // Out-of-range tags while receiving.
    send(1, 0, 0, 12'hD00);
    send(1, 200, 1, 12'hD01);
    send(1, 0, 0, 12'hD10);
    send(1, 0, 300, 12'hD11);
    drain("range");

    // Error saturation: repeated (0,0) in RECV, then finish the frame.
    send(1, 0, 0, 12'hE00);
    for (int i = 0; i < 300; i++) send(1, 0, 0, 12'(i));
    for (int i = 1; i < NPix; i++) send(1, i / Cols, i % Cols, 12'(12'hE00 + i));
    drain("sat");
    check("err_saturated", 32'(err_count), 255);

    // 256 frames wrap the frame counter back to its starting value.
    begin
      logic [7:0] fc0;
      fc0 = frame_count;
      for (int f = 0; f < 256; f++) frame(0);
      drain("wrap");
      check("frame_wrap", 32'(frame_count), 32'(fc0));
    end

    // Asynchronous reset between edges at pixel (2,1).
    for (int i = 0; i <= 2 * Cols + 1; i++) send(1, i / Cols, i % Cols, 12'(12'h300 + i));
    @(posedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    model_reset();
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b1;
    #1 mon_en = 1'b1;
    frame(0);
    drain("post_reset");
    check("post_reset_frames", 32'(frame_count), 1);

    // Randomised stream: mostly in-order with gaps, jumps, restarts and bad tags.
    cursor = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        send(0, $urandom_range(0, 3), $urandom_range(0, 4), 12'($urandom));
      end else begin
        roll = $urandom_range(0, 15);
        if (roll == 0) begin
          send(1, $urandom_range(0, 255), $urandom_range(0, 511), 12'($urandom));
        end else if (roll == 1) begin
          send(1, 0, 0, 12'($urandom));
          cursor = 1;
        end else begin
          send(1, cursor / Cols, cursor % Cols, 12'($urandom));
          cursor = (cursor + 1) % NPix;
        end
      end
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pixel_stream_receiver.md
# pixel_stream_receiver

- Receiving end of the pixel transfer link.
- Accepts the raster-ordered pixel stream (12-bit colour plus row/column tag) that the transfer interface produces from the image ROM, and checks that every pixel arrives in the expected raster position.
- Writes in-order pixels into the frame-buffer write port, and flags out-of-order or missing pixels.
- Sits between the transfer link and the masking frame buffer. It is the only writer of that buffer.

## Interface
Parameters:
- IMG_ROWS, 240, number of rows per frame (row tag range 0..IMG_ROWS-1)
- IMG_COLS, 320, number of columns per row (column tag range 0..IMG_COLS-1)

Ports:
- Clock  input  1  single system clock, rising edge
- Reset_n  input  1  asynchronous, active-low reset
- pix_valid  input  1  pixel_in/pix_row/pix_col carry a pixel this cycle
- pixel_in  input  12  RGB444 colour of the incoming pixel
- pix_row  input  8  row tag of the incoming pixel
- pix_col  input  9  column tag of the incoming pixel
- wr_en  output  1  frame-buffer write strobe
- wr_row  output  8  frame-buffer write row
- wr_col  output  9  frame-buffer write column
- wr_data  output  12  frame-buffer write data
- busy  output  1  a frame is in progress
- frame_done  output  1  one-cycle pulse: a complete, error-free frame has been written
- seq_error  output  1  one-cycle pulse: a pixel arrived out of raster order
- err_count  output  8  saturating count of sequence errors since reset
- frame_count  output  8  count of completed frames since reset, wraps 255->0

## Operation
- Internal expected position (exp_row, exp_col) advances in raster order:
  - col 0..IMG_COLS-1, then row+1, col 0.
  - After (IMG_ROWS-1, IMG_COLS-1) it returns to (0,0).
- States:
  - IDLE: waiting for a frame to start.
  - RECV: frame in progress.
- IDLE:
  - Pixels not tagged (0,0) are ignored: no write, no error.
  - A valid pixel tagged (0,0) is written, expected position advances to (0,1), state goes to RECV.
- RECV, valid pixel whose tag equals the expected position:
  - Pixel is written and the expected position advances.
  - If it was the last pixel, frame_done pulses, frame_count increments and state goes to IDLE.
- RECV, valid pixel whose tag does not equal the expected position:
  - seq_error pulses and err_count increments (saturating at 255). The pixel is not written.
  - If the tag is (0,0), the frame restarts: the pixel is written, expected position goes to (0,1), state stays RECV.
  - Otherwise state goes to IDLE.
- pix_valid low: no change in any state. Gaps in the stream are legal.
- Tags outside the valid range (row ≥ IMG_ROWS or col ≥ IMG_COLS) are treated as mismatches.
- A frame ending with an error never produces frame_done.
- busy = 1 exactly when state is RECV.

## Timing
- Registered outputs, latency 1:
  - A pixel accepted at edge N produces wr_en=1 with wr_row/wr_col/wr_data during cycle N+1.
  - frame_done and seq_error pulse in that same cycle.
- Back-to-back pixels every cycle are sustained. Throughput is 1 pixel per clock.
- wr_row/wr_col/wr_data hold their last values when wr_en=0.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE and the expected position to (0,0).
  - wr_en=0, wr_row=0, wr_col=0, wr_data=0.
  - busy=0, frame_done=0, seq_error=0, err_count=0, frame_count=0.
- After reset, a partially received frame is abandoned. The next frame must start at (0,0).
- Simultaneous last pixel and mismatch is impossible by construction: a mismatch means the pixel is not the last expected pixel.

## Structure
- Shared package `imm_pkg`:
  - IMG_ROWS, IMG_COLS, PIX_W=12, ROW_W=8, COL_W=9.
  - The receiver state enum {RX_IDLE, RX_RECV}.
- One sub-module, `raster_position_counter`:
  - Holds the (row, col) expected position.
  - Inputs: advance, restart_to_01, clear.
  - Outputs: exp_row, exp_col, is_last.
  - The top level holds the state machine, tag compare, output registers and counters.

## Test plan
- Full frame with IMG_ROWS=4, IMG_COLS=5, 20 consecutive valid pixels with pixel_in = 12'h100+index:
  - 20 writes in raster order with matching data.
  - frame_done pulses once, one cycle after pixel (3,4).
  - frame_count=1, err_count=0.
- Same frame with pix_valid low on every other cycle:
  - Identical write sequence, spread over 40 cycles.
  - No seq_error.
  - busy stays high from the first write through frame_done.
- Stream starting at (1,2) before (0,0):
  - No writes and no error until (0,0) arrives, then normal reception.
- Mid-frame skip, (0,3) sent after (0,1):
  - seq_error pulses, err_count=1, no write for (0,3), state IDLE.
  - A following (0,0) restarts the frame.
  - Mid-frame (0,0) while in RECV: seq_error pulses and (0,0) is written.
- Error saturation and wraps:
  - 300 forced mismatches give err_count=255.
  - 256 complete frames give frame_count=0.
- Reset_n asserted asynchronously between edges at pixel (2,1):
  - All outputs go to 0 immediately.
  - A fresh (0,0)-started frame completes with frame_done.
